// File: rtl/sb_cfg_pkg.sv
// Shared types and helpers for the switch-block configurable mux array.
package sb_cfg_pkg;

  // Configuration state machine encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_ACTIVE = 2'd3
  } cfg_state_t;

  // Select width for an n-input mux; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sb_cfg_mux.sv
// One routing mux: picks i_in[i_sel], drives 0 for unused select codes
// and whenever no configuration has been committed yet.
module sb_cfg_mux
  import sb_cfg_pkg::*;
#(
  parameter int MUX_SIZE = 2,
  parameter int SEL_W    = 1
) (
  input  logic [MUX_SIZE-1:0] i_in,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_valid,
  output logic                o_out
);

  // Decoded select; codes at or above MUX_SIZE match no input and fall to 0.
  always_comb begin
    o_out = 1'b0;
    for (int j = 0; j < MUX_SIZE; j++) begin
      if (i_valid && (int'(i_sel) == j)) begin
        o_out = i_in[j];
      end
    end
  end

endmodule

// File: rtl/sb_cfg_mux_array.sv
// Configurable routing-mux array with a double-buffered configuration chain.
// Bits shift serially through a shadow register; a length-checked commit
// copies the shadow into the active register that drives the muxes, so the
// routing path never sees a partially loaded configuration.
//
// Handshake: ccff_en high shifts exactly one bit (ccff_head) on that edge.
// cfg_commit is a one-cycle pulse; it succeeds only when exactly CFG_BITS
// bits have been shifted since the last commit/reset and ccff_en is low.
module sb_cfg_mux_array
  import sb_cfg_pkg::*;
#(
  parameter int N_MUX    = 18,
  parameter int MUX_SIZE = 2
) (
  input  logic                      prog_clk,
  input  logic                      pReset,
  input  logic                      ccff_head,
  input  logic                      ccff_en,
  input  logic                      cfg_commit,
  input  logic [N_MUX*MUX_SIZE-1:0] mux_in,
  output logic [N_MUX-1:0]          mux_out,
  output logic                      ccff_tail,
  output logic                      cfg_valid,
  output logic                      cfg_err
);

  localparam int SEL_W    = sel_width(MUX_SIZE);
  localparam int CFG_BITS = N_MUX * SEL_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  // Exact length for a good commit, and the saturation value marking overshift.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cfg_valid;
  logic                r_cfg_err;
  cfg_state_t          r_state;
  cfg_state_t          w_state_nxt;
  logic [CFG_BITS-1:0] w_shadow_shift;
  logic                w_commit_ok;

  // A one-bit chain has no upper slice to keep, so it degenerates to a flop.
  generate
    if (CFG_BITS == 1) begin : g_chain_one
      assign w_shadow_shift = ccff_head;
    end else begin : g_chain_many
      assign w_shadow_shift = {r_shadow[CFG_BITS-2:0], ccff_head};
    end
  endgenerate

  assign w_commit_ok = cfg_commit && !ccff_en && (r_cnt == CNT_FULL);

  // Shadow chain: one bit in at the LSB per enabled cycle, MSB feeds the tail.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_shadow <= '0;
    end else if (ccff_en) begin
      r_shadow <= w_shadow_shift;
    end
  end

  // Shift counter; any commit clears it, including one that races a shift.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_cnt <= '0;
    end else if (cfg_commit) begin
      r_cnt <= '0;
    end else if (ccff_en && (r_cnt != CNT_SAT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Commit outcome: good commits swap in the shadow, bad ones only flag.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_active    <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else if (cfg_commit) begin
      if (w_commit_ok) begin
        r_active    <= r_shadow;
        r_cfg_valid <= 1'b1;
        r_cfg_err   <= 1'b0;
      end else begin
        r_cfg_err   <= 1'b1;
      end
    end
  end

  // Next state; a failed commit returns to whichever resting state preceded
  // the load, which is ACTIVE exactly when a configuration is already live.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_commit) begin
      if (w_commit_ok || r_cfg_valid) begin
        w_state_nxt = ST_ACTIVE;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE:   if (ccff_en)  w_state_nxt = ST_LOAD;
        ST_LOAD:   if (!ccff_en) w_state_nxt = ST_HOLD;
        ST_HOLD:   if (ccff_en)  w_state_nxt = ST_LOAD;
        ST_ACTIVE: if (ccff_en)  w_state_nxt = ST_LOAD;
        default:                 w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign ccff_tail = r_shadow[CFG_BITS-1];
  assign cfg_valid = r_cfg_valid;
  assign cfg_err   = r_cfg_err;

  // Routing muxes, each reading its own select field of the active register.
  generate
    for (genvar g = 0; g < N_MUX; g++) begin : g_mux
      sb_cfg_mux #(
        .MUX_SIZE (MUX_SIZE),
        .SEL_W    (SEL_W)
      ) u_mux (
        .i_in    (mux_in[g*MUX_SIZE +: MUX_SIZE]),
        .i_sel   (r_active[g*SEL_W +: SEL_W]),
        .i_valid (r_cfg_valid),
        .o_out   (mux_out[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sb_cfg_mux_array.sv
// Bench for sb_cfg_mux_array: one default instance (18 x 2-input) and one
// 4 x 3-input instance. A history-based model predicts every output each
// cycle; directed steps add literal expectations.
module tb_sb_cfg_mux_array;

  // ---------------- clock / reset ----------------
  logic prog_clk;
  logic pReset;

  initial prog_clk = 1'b0;
  initial forever #5 prog_clk = ~prog_clk;

  // ---------------- DUT A: defaults ----------------
  logic        a_head, a_en, a_commit;
  logic [35:0] a_in;
  logic [17:0] a_out;
  logic        a_tail, a_valid, a_err;

  sb_cfg_mux_array u_dut_a (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .ccff_head  (a_head),
    .ccff_en    (a_en),
    .cfg_commit (a_commit),
    .mux_in     (a_in),
    .mux_out    (a_out),
    .ccff_tail  (a_tail),
    .cfg_valid  (a_valid),
    .cfg_err    (a_err)
  );

  // ---------------- DUT B: 4 muxes of 3 inputs ----------------
  logic        b_head, b_en, b_commit;
  logic [11:0] b_in;
  logic [3:0]  b_out;
  logic        b_tail, b_valid, b_err;

  sb_cfg_mux_array #(.N_MUX(4), .MUX_SIZE(3)) u_dut_b (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .ccff_head  (b_head),
    .ccff_en    (b_en),
    .cfg_commit (b_commit),
    .mux_in     (b_in),
    .mux_out    (b_out),
    .ccff_tail  (b_tail),
    .cfg_valid  (b_valid),
    .cfg_err    (b_err)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Every bit ever shifted is kept in order; the shadow is simply the most
  // recent CFG_BITS of them, newest at bit 0.
  int cfgbits [2] = '{18, 8};
  int selw    [2] = '{1, 2};
  int nmux    [2] = '{18, 4};
  int msz     [2] = '{2, 3};

  bit m_hist  [2][4096];
  int m_n     [2];
  int m_cnt   [2];
  int m_sel   [2][18];
  bit m_valid [2];
  bit m_err   [2];

  function automatic bit shadow_bit(input int d, input int b);
    int idx;
    idx = m_n[d] - 1 - b;
    return (idx >= 0) ? m_hist[d][idx] : 1'b0;
  endfunction

  task automatic model_reset(input int d);
    m_n[d] = 0;
    m_cnt[d] = 0;
    m_valid[d] = 1'b0;
    m_err[d] = 1'b0;
    for (int i = 0; i < 18; i++) m_sel[d][i] = 0;
  endtask

  task automatic model_step(input int d, input logic en, input logic head, input logic commit);
    bit ok;
    int s;
    ok = commit && !en && (m_cnt[d] == cfgbits[d]);
    if (en) begin
      m_hist[d][m_n[d]] = head;
      m_n[d]++;
      m_cnt[d]++;
    end
    if (commit) begin
      if (ok) begin
        for (int i = 0; i < nmux[d]; i++) begin
          s = 0;
          for (int k = 0; k < selw[d]; k++)
            if (shadow_bit(d, i*selw[d] + k)) s += (1 << k);
          m_sel[d][i] = s;
        end
        m_valid[d] = 1'b1;
        m_err[d] = 1'b0;
      end else begin
        m_err[d] = 1'b1;
      end
      m_cnt[d] = 0;
    end
  endtask

  function automatic logic [17:0] exp_out(input int d);
    logic [35:0] in;
    logic [17:0] r;
    int s;
    r = '0;
    in = (d == 0) ? a_in : {24'b0, b_in};
    for (int i = 0; i < nmux[d]; i++) begin
      s = m_sel[d][i];
      if (m_valid[d] && (s < msz[d])) r[i] = in[i*msz[d] + s];
    end
    return r;
  endfunction

  // Model update on each edge (or immediately on asynchronous reset).
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge prog_clk or negedge pReset);
      if (!pReset) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, a_en, a_head, a_commit);
        model_step(1, b_en, b_head, b_commit);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge prog_clk);
    chk("a_mux_out", a_out, exp_out(0));
    chk("a_tail",    a_tail, shadow_bit(0, cfgbits[0]-1));
    chk("a_valid",   a_valid, m_valid[0]);
    chk("a_err",     a_err, m_err[0]);
    chk("b_mux_out", b_out, exp_out(1));
    chk("b_tail",    b_tail, shadow_bit(1, cfgbits[1]-1));
    chk("b_valid",   b_valid, m_valid[1]);
    chk("b_err",     b_err, m_err[1]);
  end

  // ---------------- driver tasks ----------------
  // One call = one clock edge with the given controls on DUT d.
  task automatic cyc(input int d, input logic en, input logic head, input logic commit);
    a_in = {4'($urandom_range(0, 15)), 32'($urandom)};
    b_in = 12'($urandom_range(0, 4095));
    if (d == 0) begin
      a_en = en; a_head = head; a_commit = commit;
    end else begin
      b_en = en; b_head = head; b_commit = commit;
    end
    @(posedge prog_clk);
    #1;
    a_en = 1'b0; a_commit = 1'b0;
    b_en = 1'b0; b_commit = 1'b0;
  endtask

  task automatic shift(input int d, input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(d, 1'b1, val[i], 1'b0);
  endtask

  task automatic commit(input int d);
    cyc(d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit_a(input string name, input logic [35:0] in, input logic [17:0] exp);
    a_in = in;
    #1;
    chk(name, a_out, exp);
  endtask

  task automatic lit_b(input string name, input logic [11:0] in, input logic [3:0] exp);
    b_in = in;
    #1;
    chk(name, b_out, exp);
  endtask

  // ---------------- directed sequence ----------------
  logic tbits [36];

  initial begin
    pReset = 1'b0;
    a_head = 1'b0; a_en = 1'b0; a_commit = 1'b0;
    b_head = 1'b0; b_en = 1'b0; b_commit = 1'b0;
    a_in = {4'($urandom_range(0, 15)), 32'($urandom)};
    b_in = 12'($urandom_range(0, 4095));

    // Reset state with random routing inputs.
    repeat (2) @(posedge prog_clk);
    #1;
    chk("rst_a_out",   a_out, 18'h0);
    chk("rst_a_tail",  a_tail, 1'b0);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_err",   a_err, 1'b0);
    chk("rst_b_out",   b_out, 4'h0);
    pReset = 1'b1;
    idle(2);

    // Default config 0x2AAAA: odd muxes pick input 1, even muxes input 0.
    shift(0, 64'h2AAAA, 18);
    idle(1);
    commit(0);
    chk("def_valid", a_valid, 1'b1);
    chk("def_err",   a_err, 1'b0);
    lit_a("def_in5", 36'h555555555, 18'h15555);
    lit_a("def_inA", 36'hAAAAAAAAA, 18'h2AAAA);
    idle(3);

    // Short load fails and leaves routing alone; a full load recovers.
    shift(0, 64'h1FFFF, 17);
    commit(0);
    chk("short_err", a_err, 1'b1);
    lit_a("short_keep", 36'hAAAAAAAAA, 18'h2AAAA);
    shift(0, 64'h3FFFF, 18);
    commit(0);
    chk("full_err_clr", a_err, 1'b0);
    lit_a("full_all1", 36'hAAAAAAAAA, 18'h3FFFF);

    // Reload while active: old config holds until the commit edge.
    shift(0, 64'h0, 9);
    lit_a("reload_mid", 36'h555555555, 18'h0);
    shift(0, 64'h0, 9);
    idle(1);
    lit_a("reload_hold", 36'h555555555, 18'h0);
    commit(0);
    lit_a("reload_new", 36'h555555555, 18'h3FFFF);

    // Overshift commit fails.
    shift(0, 64'hFFFFF, 20);
    commit(0);
    chk("over_err", a_err, 1'b1);
    lit_a("over_keep", 36'h555555555, 18'h3FFFF);

    // 36-bit stream: tail replays the first 18 bits 18 shifts later.
    for (int k = 0; k < 36; k++) begin
      tbits[k] = 1'($urandom_range(0, 1));
      cyc(0, 1'b1, tbits[k], 1'b0);
      if (k >= 17) chk("tail_delay", a_tail, tbits[k-17]);
    end
    commit(0);
    chk("over36_err", a_err, 1'b1);

    // Commit racing a shift fails and clears the count.
    shift(0, 64'h155, 17);
    cyc(0, 1'b1, 1'b1, 1'b1);
    chk("race_err", a_err, 1'b1);
    commit(0);
    chk("race_cnt_clr", a_err, 1'b1);
    shift(0, 64'h2AAAA, 18);
    commit(0);
    chk("recover_err", a_err, 1'b0);
    lit_a("recover_out", 36'hAAAAAAAAA, 18'h2AAAA);

    // 3-input muxes: sel 3,2,1,0 on muxes 0..3 (shadow 8'h1B).
    lit_b("b_unconf", 12'hFFF, 4'h0);
    shift(1, 64'h1B, 8);
    lit_b("b_precommit", 12'hFFF, 4'h0);
    commit(1);
    chk("b_valid_set", b_valid, 1'b1);
    lit_b("b_sel_fff", 12'hFFF, 4'b1110);
    lit_b("b_sel_020", 12'h020, 4'b0010);
    idle(3);

    // Asynchronous reset mid-shift clears everything.
    shift(0, 64'h15, 5);
    shift(1, 64'h5, 3);
    a_en = 1'b1; a_head = 1'b1;
    b_en = 1'b1; b_head = 1'b1;
    #2;
    pReset = 1'b0;
    #1;
    chk("mrst_a_out",   a_out, 18'h0);
    chk("mrst_a_tail",  a_tail, 1'b0);
    chk("mrst_a_valid", a_valid, 1'b0);
    chk("mrst_b_out",   b_out, 4'h0);
    chk("mrst_b_valid", b_valid, 1'b0);
    a_en = 1'b0; b_en = 1'b0;
    @(posedge prog_clk);
    #1;
    pReset = 1'b1;
    idle(3);
    lit_a("post_rst_out", 36'hFFFFFFFFF, 18'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sb_cfg_mux_array.md
# sb_cfg_mux_array

Parametrised, configurable routing-mux array for the switch-block tiles. It generalises the fixed 18 × size-2 switch-block muxes to N_MUX muxes of arbitrary size. It adds a double-buffered configuration chain: bits shift through a shadow register and move to the active register only on a length-checked commit. Routing never sees a half-loaded configuration. The block sits between the tile's routing tracks and the global configuration chain (ccff_head → ccff_tail).

## Interface
Parameters:
- N_MUX, 18, number of routing muxes (≥1).
- MUX_SIZE, 2, inputs per mux (≥2).
- SEL_W, derived = max(1, clog2(MUX_SIZE)), select bits per mux; not overridable.
- CFG_BITS, derived = N_MUX*SEL_W, configuration chain length.

Ports:
- prog_clk  in  1  the single clock; all state updates on its rising edge.
- pReset  in  1  reset, asynchronous assert, active-low.
- ccff_head  in  1  serial configuration data in.
- ccff_en  in  1  shift enable; one bit shifts per cycle while high.
- cfg_commit  in  1  single-cycle pulse; requests shadow → active transfer.
- mux_in  in  N_MUX*MUX_SIZE  routing inputs; mux i input j = mux_in[i*MUX_SIZE+j].
- mux_out  out  N_MUX  routing outputs.
- ccff_tail  out  1  serial configuration data out, to the next block in the chain.
- cfg_valid  out  1  high once any commit has succeeded.
- cfg_err  out  1  sticky high after a failed commit; cleared by the next successful commit.

## Operation
- Shadow register shadow[CFG_BITS-1:0]. On a shift: shadow ← {shadow[CFG_BITS-2:0], ccff_head}. ccff_tail = shadow[CFG_BITS-1], so the first bit shifted in lands in the MSB of mux N_MUX-1's select.
- Bit counter cnt, width clog2(CFG_BITS+2). Increments on each shift and saturates at CFG_BITS+1, which marks overshift.
- State machine:
  - IDLE: no configuration since reset. ccff_en moves to LOAD.
  - LOAD: shifting. ccff_en low moves to HOLD.
  - HOLD: waiting for commit. ccff_en moves back to LOAD, and cnt keeps counting. A commit moves to ACTIVE on success, or back to IDLE/ACTIVE on failure (whichever state was current before loading).
  - ACTIVE: configuration committed. ccff_en moves to LOAD while routing keeps using the old active configuration.
- Commit succeeds iff cnt == CFG_BITS and ccff_en is low. On success: active ← shadow, cfg_valid ← 1, cfg_err ← 0, cnt ← 0.
- Any other commit fails: cfg_err ← 1, cnt ← 0, active unchanged, shadow unchanged.
- cfg_commit and ccff_en high in the same cycle: the shift happens, the commit fails (cfg_err ← 1), and cnt is cleared after the shift.
- mux i: sel = active[i*SEL_W +: SEL_W]. mux_out[i] = mux_in[i*MUX_SIZE+sel] if sel < MUX_SIZE, else 0.
- mux_out is forced to 0 while cfg_valid = 0.

## Timing
- Reset (pReset low, asynchronous): shadow = 0, active = 0, cnt = 0, state IDLE, cfg_valid = 0, cfg_err = 0, ccff_tail = 0, mux_out = 0.
- Reset asserted mid-shift or mid-commit aborts the operation; all state returns to reset values.
- Reset deassertion is synchronised externally; the first edge after deassertion is a normal cycle.
- Chain latency: ccff_head → ccff_tail is CFG_BITS shift cycles. ccff_tail changes only on shift edges.
- Commit at edge k: active, cfg_valid and cfg_err update at edge k. mux_out reflects the new configuration combinationally after edge k.
- Routing path mux_in → mux_out is purely combinational, with zero cycles of latency.

## Structure
- Package sb_cfg_pkg holds:
  - the state enum (IDLE, LOAD, HOLD, ACTIVE);
  - function sel_width(n) returning max(1, clog2(n)).
- Sub-module sb_cfg_mux: one MUX_SIZE-input mux with out-of-range and cfg_valid gating. It is generated N_MUX times.
- The shadow register, active register, counter and FSM live in the top module.

## Test plan
- Reset: pReset low with random mux_in → mux_out = 0, ccff_tail = 0, cfg_valid = 0, cfg_err = 0.
- Defaults (N_MUX=18, MUX_SIZE=2): shift 18 bits of 0x2AAAA MSB-first, then commit → cfg_valid = 1. Odd muxes select input 1, even muxes select input 0; verify all 18 against random mux_in.
- Short load: shift 17 bits, then commit → cfg_err = 1, active unchanged, mux_out unchanged. A following correct 18-bit load plus commit → cfg_err = 0.
- Overshift: shift 20 bits and commit → cfg_err = 1. Separately, shift 36 bits → ccff_tail reproduces the first 18 input bits, delayed by 18 cycles.
- MUX_SIZE=3, N_MUX=4 (SEL_W=2): configure sel = 3 on mux 0 → mux_out[0] = 0. sel = 2 on mux 1 → mux_out[1] = mux_in[5].
- Reload while ACTIVE: shift a new pattern → mux_out follows the old configuration until the commit edge, then switches. Assert pReset mid-shift → all outputs return to 0.
